// File: rtl/gost89_pkg.sv
// Shared types and helpers for the GOST 28147-89 S-box inverter.
//   in_enum      : nibble index (0..15) into a 64-bit S-box row
//   inv_state_e  : controller states
//   nib_sel()    : extracts nibble i of a row using the forward packing,
//                  where nibble 0 sits in the most significant position.
package gost89_pkg;

  localparam int SBOX_ROW_W = 64;
  localparam int NIBBLES    = 16;

  typedef logic [3:0] in_enum;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } inv_state_e;

  function automatic logic [3:0] nib_sel(input logic [SBOX_ROW_W-1:0] row,
                                         input in_enum i);
    return row[SBOX_ROW_W-1-4*i -: 4];
  endfunction

endpackage

// File: rtl/gost89_sbox_inv_row.sv
// One S-box row of the inverter: holds the inverse table being built,
// the 16-bit "output value already produced" vector and the error flag.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : start of a new table, wipes inverse/seen/error
//   scan_en    : process forward entry idx this cycle
//   idx        : forward input nibble currently being scanned
//   fwd_row    : latched forward row (forward packing)
//   inv_row    : inverse row (same packing)
//   err        : row is not a permutation (some output value repeated)
//   seen_full  : every output value has been produced at least once
module gost89_sbox_inv_row
  import gost89_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  scan_en,
  input  in_enum                idx,
  input  logic [SBOX_ROW_W-1:0] fwd_row,
  output logic [SBOX_ROW_W-1:0] inv_row,
  output logic                  err,
  output logic                  seen_full
);

  logic [SBOX_ROW_W-1:0] inv_q;
  logic [NIBBLES-1:0]    seen_q;
  logic                  err_q;
  logic [3:0]            v;

  assign v = nib_sel(fwd_row, idx);

  // NOTE: the inverse table is reset even though it behaves like a small
  // memory: downstream logic may look at sbox_inv right after reset and
  // must see zeros, not power-up garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q  <= '0;
      seen_q <= '0;
      err_q  <= 1'b0;
    end else if (clear) begin
      inv_q  <= '0;
      seen_q <= '0;
      err_q  <= 1'b0;
    end else if (scan_en) begin
      // Later indices overwrite earlier ones, so duplicates resolve to the
      // last writer; nibbles never written stay zero.
      for (int n = 0; n < NIBBLES; n++) begin
        if (v == n[3:0]) begin
          inv_q[SBOX_ROW_W-1-4*n -: 4] <= idx;
        end
      end
      // NOTE: non-blocking assignments here read the pre-edge seen_q, so the
      // duplicate test looks at history only, never at this cycle's own bit.
      err_q     <= err_q | seen_q[v];
      seen_q[v] <= 1'b1;
    end
  end

  assign inv_row   = inv_q;
  assign err       = err_q;
  assign seen_full = &seen_q;

endmodule

// File: rtl/gost89_sbox_inverter.sv
// Builds inverse GOST 28147-89 S-box tables for the decryption path.
// A forward table is accepted in IDLE, scanned one input nibble per cycle
// (all rows in parallel) for 16 cycles, then presented until the consumer
// takes it. Result appears 17 cycles after the input handshake.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : forward table valid       in_ready  : can accept a table
//   sbox_in    : forward rows, row k at [64k+63:64k]
//   out_valid  : inverse tables valid      out_ready : consumer accepts
//   sbox_inv   : inverse rows, same packing
//   inv_error  : bit k set when row k is not a permutation
module gost89_sbox_inverter
  import gost89_pkg::*;
#(
  parameter int NUM_SBOX = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SBOX_ROW_W*NUM_SBOX-1:0] sbox_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SBOX_ROW_W*NUM_SBOX-1:0] sbox_inv,
  output logic [NUM_SBOX-1:0]            inv_error
);

  inv_state_e                     state_q, state_d;
  in_enum                         idx_q;
  logic [SBOX_ROW_W*NUM_SBOX-1:0] fwd_q;
  logic [NUM_SBOX-1:0]            seen_full;
  logic                           load;
  logic                           scan_en;

  assign load    = in_valid && in_ready;
  assign scan_en = (state_q == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        idx_q <= '0;
      end else if (scan_en && idx_q != in_enum'(NIBBLES - 1)) begin
        // Hold at 15 on the last scan cycle instead of wrapping to 0.
        idx_q <= idx_q + in_enum'(1);
      end
    end
  end

  // The forward copy is always overwritten before the scan reads it, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      fwd_q <= sbox_in;
    end
  end

  // NOTE: every output of this block is assigned a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == in_enum'(NIBBLES - 1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_row
    gost89_sbox_inv_row u_row (
      .clk       (clk),
      .rst       (rst),
      .clear     (load),
      .scan_en   (scan_en),
      .idx       (idx_q),
      .fwd_row   (fwd_q[SBOX_ROW_W*k +: SBOX_ROW_W]),
      .inv_row   (sbox_inv[SBOX_ROW_W*k +: SBOX_ROW_W]),
      .err       (inv_error[k]),
      .seen_full (seen_full[k])
    );
  end

  // 16 writes into 16 slots: a repeat happened exactly when a slot was
  // missed, so the duplicate flag and the coverage vector must agree.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE) begin
      assert (inv_error == ~seen_full);
    end
  end

endmodule

// File: tb/tb_gost89_sbox_inverter.sv
module tb_gost89_sbox_inverter;

  localparam int NS = 8;
  localparam int W  = 64 * NS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  sbox_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sbox_inv;
  logic [NS-1:0] inv_error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  gost89_sbox_inverter #(.NUM_SBOX(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sbox_in   (sbox_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sbox_inv  (sbox_inv),
    .inv_error (inv_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [63:0] ID_ROW  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] REV_ROW = 64'hFEDC_BA98_7654_3210;

  // Reference: for each row, walk x = 0..15 and place x at slot fwd[x]
  // (later x wins); a row is bad when any output value count is not 1.
  function automatic void model(input logic [W-1:0] fwd,
                                output logic [W-1:0] inv,
                                output logic [NS-1:0] err);
    inv = '0;
    err = '0;
    for (int k = 0; k < NS; k++) begin
      logic [63:0] r;
      logic [63:0] ir;
      int cnt [16];
      r  = fwd[64*k +: 64];
      ir = '0;
      for (int j = 0; j < 16; j++) cnt[j] = 0;
      for (int x = 0; x < 16; x++) begin
        int v;
        v = int'(r[63-4*x -: 4]);
        ir[63-4*v -: 4] = 4'(x);
        cnt[v] = cnt[v] + 1;
      end
      for (int j = 0; j < 16; j++) if (cnt[j] != 1) err[k] = 1'b1;
      inv[64*k +: 64] = ir;
    end
  endfunction

  function automatic logic [W-1:0] all_rows(input logic [63:0] r);
    logic [W-1:0] t;
    for (int k = 0; k < NS; k++) t[64*k +: 64] = r;
    return t;
  endfunction

  function automatic logic [63:0] rand_perm();
    logic [3:0]  p [16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) p[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j;
      logic [3:0] t;
      j = int'($urandom_range(i, 0));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 16; i++) r[63-4*i -: 4] = p[i];
    return r;
  endfunction

  // Presents a table (called at posedge+1 while idle), then returns the
  // number of edges after the handshake edge until out_valid, or -1.
  task automatic send_and_wait(input logic [W-1:0] data, output int lat);
    in_valid = 1'b1;
    sbox_in  = data;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sbox_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_handshake: in_ready/out_valid got %b expected 10", {in_ready, out_valid});
    end
    n_cmp++;
    if (sbox_inv !== '0 || inv_error !== '0) begin
      n_err++;
      $display("FAIL reset_data: sbox_inv %h err %h expected all zero", sbox_inv, inv_error);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]  vec [4];
    logic [W-1:0]  exp_inv;
    logic [NS-1:0] exp_err;
    int lat;
    vec[0] = all_rows(ID_ROW);
    vec[1] = all_rows(REV_ROW);
    vec[2] = all_rows(ID_ROW);
    vec[2][63:0] = 64'h4A92_D80E_6B1C_7F53;
    vec[3] = all_rows(ID_ROW);
    vec[3][64*3 +: 64] = 64'h0;
    for (int t = 0; t < 4; t++) begin
      model(vec[t], exp_inv, exp_err);
      send_and_wait(vec[t], lat);
      n_cmp++;
      if (lat != 16) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d edges expected 16", t, lat);
      end
      n_cmp++;
      if (sbox_inv !== exp_inv || inv_error !== exp_err) begin
        n_err++;
        $display("FAIL dir%0d_result: inv %h err %h expected inv %h err %h", t, sbox_inv, inv_error, exp_inv, exp_err);
      end
      if (t == 2) begin
        logic [63:0] fr;
        logic [63:0] ir;
        fr = vec[2][63:0];
        ir = sbox_inv[63:0];
        n_cmp++;
        if (ir !== 64'h6A3F_0E8C_5219_B47D) begin
          n_err++;
          $display("FAIL dir_vector_const: got %h expected 6a3f0e8c5219b47d", ir);
        end
        for (int x = 0; x < 16; x++) begin
          int v;
          v = int'(fr[63-4*x -: 4]);
          n_cmp++;
          if (ir[63-4*v -: 4] !== 4'(x)) begin
            n_err++;
            $display("FAIL inv_of_fwd x=%0d: got %h expected %h", x, ir[63-4*v -: 4], 4'(x));
          end
        end
      end
      if (t == 3) begin
        n_cmp++;
        if (inv_error !== 8'h08 || sbox_inv[64*3 +: 64] !== 64'hF000_0000_0000_0000) begin
          n_err++;
          $display("FAIL zero_row: err %h row3 %h expected 08 f000000000000000", inv_error, sbox_inv[64*3 +: 64]);
        end
      end
      consume();
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_err++;
        $display("FAIL dir%0d_release: in_ready/out_valid got %b expected 10", t, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0]  d;
    logic [W-1:0]  exp_inv;
    logic [NS-1:0] exp_err;
    int lat;
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < NS; k++) begin
        if ($urandom_range(3, 0) == 0) d[64*k +: 64] = {$urandom, $urandom};
        else                           d[64*k +: 64] = rand_perm();
      end
      model(d, exp_inv, exp_err);
      send_and_wait(d, lat);
      n_cmp++;
      if (lat != 16) begin
        n_err++;
        $display("FAIL rand%0d_latency: got %0d edges expected 16", t, lat);
      end
      n_cmp++;
      if (sbox_inv !== exp_inv || inv_error !== exp_err) begin
        n_err++;
        $display("FAIL rand%0d_result: inv %h err %h expected inv %h err %h", t, sbox_inv, inv_error, exp_inv, exp_err);
      end
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #0;
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  d;
    logic [W-1:0]  exp_inv;
    logic [NS-1:0] exp_err;
    logic [W-1:0]  snap_inv;
    logic [NS-1:0] snap_err;
    int lat;
    int bad;
    d = all_rows(REV_ROW);
    d[64*5 +: 64] = rand_perm();
    model(d, exp_inv, exp_err);
    send_and_wait(d, lat);
    n_cmp++;
    if (lat != 16) begin
      n_err++;
      $display("FAIL bp_latency: got %0d edges expected 16", lat);
    end
    snap_inv = sbox_inv;
    snap_err = inv_error;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      sbox_in  = {16{$urandom}};
      @(posedge clk); #1;
      if (!out_valid || in_ready || sbox_inv !== snap_inv || inv_error !== snap_err) bad++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    end
    n_cmp++;
    if (sbox_inv !== exp_inv || inv_error !== exp_err) begin
      n_err++;
      $display("FAIL bp_result: inv %h err %h expected inv %h err %h", sbox_inv, inv_error, exp_inv, exp_err);
    end
    consume();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release: in_ready/out_valid got %b expected 10", {in_ready, out_valid});
    end
    // Pulsed data must not have been taken: a fresh table runs cleanly.
    d = all_rows(ID_ROW);
    send_and_wait(d, lat);
    n_cmp++;
    if (lat != 16 || sbox_inv !== d || inv_error !== '0) begin
      n_err++;
      $display("FAIL bp_next: lat %0d inv %h err %h expected 16 identity 00", lat, sbox_inv, inv_error);
    end
    consume();
  endtask

  task automatic test_mid_scan_reset();
    logic [W-1:0]  exp_inv;
    logic [NS-1:0] exp_err;
    logic [W-1:0]  d;
    int lat;
    int seen_valid;
    in_valid = 1'b1;
    sbox_in  = all_rows(REV_ROW);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10 || sbox_inv !== '0 || inv_error !== '0) begin
      n_err++;
      $display("FAIL midrst_state: rdy/vld %b inv %h err %h expected 10 zero zero", {in_ready, out_valid}, sbox_inv, inv_error);
    end
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid++;
    end
    n_cmp++;
    if (seen_valid != 0) begin
      n_err++;
      $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", seen_valid);
    end
    d = all_rows(rand_perm());
    d[64*6 +: 64] = {$urandom, $urandom};
    model(d, exp_inv, exp_err);
    send_and_wait(d, lat);
    n_cmp++;
    if (lat != 16 || sbox_inv !== exp_inv || inv_error !== exp_err) begin
      n_err++;
      $display("FAIL midrst_fresh: lat %0d inv %h err %h expected 16 inv %h err %h", lat, sbox_inv, inv_error, exp_inv, exp_err);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]  d;
    logic [W-1:0]  exp_inv;
    logic [NS-1:0] exp_err;
    int lat;
    int t_prev;
    int t_now;
    out_ready = 1'b1;
    t_prev = -1;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NS; k++) d[64*k +: 64] = rand_perm();
      model(d, exp_inv, exp_err);
      in_valid = 1'b1;
      sbox_in  = d;
      @(posedge clk);
      t_now = cyc;
      #1 in_valid = 1'b0;
      if (t_prev >= 0) begin
        n_cmp++;
        if (t_now - t_prev != 18) begin
          n_err++;
          $display("FAIL b2b_period%0d: got %0d cycles expected 18", t, t_now - t_prev);
        end
      end
      t_prev = t_now;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
        @(posedge clk); #1;
        if (out_valid) begin
          lat = n;
          break;
        end
      end
      n_cmp++;
      if (lat != 16 || sbox_inv !== exp_inv || inv_error !== exp_err) begin
        n_err++;
        $display("FAIL b2b%0d_result: lat %0d inv %h err %h expected 16 inv %h err %h", t, lat, sbox_inv, inv_error, exp_inv, exp_err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_scan_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gost89_sbox_inverter.md
Name: gost89_sbox_inverter

Overview:
- Builds the inverse substitution tables for a GOST 28147-89 S-box set, so the decryption datapath can map an S-box output nibble back to its input nibble.
- Input uses the forward packing: entry for nibble x sits at bits [63-4x -: 4] of each 64-bit row. Output uses the same packing.
- Sits between the key/S-box configuration loader and the cipher core. Checks each row for bijectivity while scanning.

Parameters:
- NUM_SBOX, 8, number of 64-bit S-box rows processed in parallel; row k occupies bits [64k+63 : 64k].

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  forward table valid
- in_ready  output  1  block can accept a table
- sbox_in  input  64*NUM_SBOX  forward S-box rows
- out_valid  output  1  inverse tables valid
- out_ready  input  1  consumer accepts result
- sbox_inv  output  64*NUM_SBOX  inverse S-box rows, same packing
- inv_error  output  NUM_SBOX  bit k set means row k is not a permutation

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - sbox_inv = 0, inv_error = 0, idx = 0, seen = 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at cycle T: latch sbox_in, clear inverse registers, clear the seen vectors (16 bits per row), set idx = 0, go to SCAN.
- SCAN (cycles T+1 .. T+16), in_ready = 0. Each cycle, for every row k in parallel:
  - v = fwd[k][63-4*idx -: 4].
  - Write inv[k][63-4*v -: 4] = idx.
  - If seen[k][v] is already set, set err[k]; then set seen[k][v].
  - idx increments by 1. When idx = 15, go to DONE next cycle.
- DONE:
  - out_valid = 1 starting at cycle T+17. sbox_inv and inv_error are stable while out_valid = 1.
  - On out_valid && out_ready: go to IDLE, out_valid = 0 next cycle, in_ready = 1 next cycle.
  - Outputs hold until handshake (backpressure can last any number of cycles).
- Latency: 17 cycles from input handshake to out_valid. Throughput: one table per 18 cycles minimum.
- Duplicate rule: the later index overwrites, so the last write wins. Unwritten inverse nibbles stay 0.
- inv_error[k] is equivalent to "seen[k] is not all ones after 16 cycles". The two checks must agree; assert this in simulation.
- in_valid while busy: ignored, because in_ready = 0. The source must hold its data until accepted.
- idx is 4 bits and is never allowed to wrap inside SCAN.
- rst asserted in any state, including mid-SCAN or DONE with out_ready low:
  - Next cycle returns to reset values.
  - The partial result is discarded and out_valid is never asserted for it.
- Correctness property: for every permutation row k and every x, inv[k][fwd[k][x]] = x.

Decomposition:
- Package gost89_pkg holds:
  - in_enum (nibble index type),
  - localparam SBOX_ROW_W = 64 and NIBBLES = 16,
  - FSM typedef inv_state_e {IDLE, SCAN, DONE},
  - function nib_sel(row, i) returning row[63-4*i -: 4].
- One natural sub-module: gost89_sbox_inv_row.
  - Holds the per-row inverse register, the seen vector and the error flag.
  - Instantiated NUM_SBOX times, driven by the shared idx and FSM controls.

Test Plan:
- Identity row 64'h0123_4567_89AB_CDEF in all rows -> at T+17, sbox_inv rows = 64'h0123_4567_89AB_CDEF, inv_error = 0.
- Reversed row 64'hFEDC_BA98_7654_3210 -> inverse = 64'hFEDC_BA98_7654_3210, inv_error = 0.
- Row 64'h4A92_D80E_6B1C_7F53 in row 0, identity elsewhere:
  - row 0 inverse = 64'h6A3F_0E8C_5219_B47D, inv_error = 0.
  - Bench also checks inv[fwd[x]] = x for all x.
- Row 3 = 64'h0 (others identity) -> inv_error = 8'h08, row 3 inverse = 64'hF000_0000_0000_0000, other rows identity.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid; pulse in_valid with new data meanwhile:
  - outputs stay stable, in_ready stays 0, new data is not taken;
  - after handshake, in_ready = 1 on the next cycle.
- Reset at cycle T+8 (mid-SCAN):
  - next cycle out_valid = 0, in_ready = 1, sbox_inv = 0, inv_error = 0;
  - a fresh table then completes in 17 cycles with correct results.
